// File: rtl/sac_dualrail_fifo.sv
`default_nettype none
// ============================================================================
// sac_dualrail_fifo : clocked words buffered in a FIFO, emitted on a W-bit
//                     dual-rail four-phase return-to-zero channel
// Revision          : 1.0
// ============================================================================
module sac_dualrail_fifo #(
  parameter int           W           = 8,
  parameter int           DEPTH       = 4,
  parameter int           SYNC_STAGES = 2,
  parameter bit           IGNORE_ACK  = 1'b0,
  parameter int           HOLD_CYC    = 2,
  parameter bit           RESET_TOKEN = 1'b0,
  parameter logic [W-1:0] RESET_VAL   = '0
) (
  input  logic         ck,
  input  logic         rst_b,
  input  logic [W-1:0] a,
  input  logic         en,
  output logic         full,
  output logic         ovf,
  output logic [W-1:0] z_d0,
  output logic [W-1:0] z_d1,
  input  logic         z_ack
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RTZ   = 2'd2
  } state_t;

  logic [W-1:0]           mem_q [DEPTH];
  logic [W-1:0]           mem_d [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [W-1:0]           z_d0_q, z_d0_d;
  logic [W-1:0]           z_d1_q, z_d1_d;

  logic w_wr;
  logic w_pop;
  logic w_ack_s;
  logic w_hold_done;
  logic w_fwd_ok;
  logic w_rtz_ok;

  assign w_ack_s     = sync_q[SYNC_STAGES-1];
  assign w_hold_done = (hold_q == HW'(HOLD_CYC - 1));
  // In timed mode the hold counter stands in for both acknowledge edges.
  assign w_fwd_ok    = IGNORE_ACK ? w_hold_done : w_ack_s;
  assign w_rtz_ok    = IGNORE_ACK ? w_hold_done : !w_ack_s;
  assign w_wr        = en && !full_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    z_d0_d  = z_d0_q;
    z_d1_d  = z_d1_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          w_pop   = 1'b1;
          state_d = S_DRIVE;
          hold_d  = '0;
        end
      end
      S_DRIVE: begin
        if (w_fwd_ok) begin
          z_d0_d  = '0;
          z_d1_d  = '0;
          state_d = S_RTZ;
          hold_d  = '0;
        end else begin
          hold_d = HW'(hold_q + 1'b1);
        end
      end
      S_RTZ: begin
        if (w_rtz_ok) begin
          hold_d = '0;
          if (count_q != '0) begin
            w_pop   = 1'b1;
            state_d = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          hold_d = HW'(hold_q + 1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        z_d0_d  = '0;
        z_d1_d  = '0;
        hold_d  = '0;
      end
    endcase
    if (w_pop) begin
      z_d1_d = mem_q[rd_ptr_q];
      z_d0_d = ~mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (w_wr) begin
      mem_d[wr_ptr_q] = a;
    end
    wr_ptr_d = w_wr  ? AW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = w_pop ? AW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = CW'(count_q + CW'(w_wr) - CW'(w_pop));
    full_d   = (count_d == CW'(DEPTH));
    ovf_d    = ovf_q || (en && full_q);
    sync_d   = SYNC_STAGES'({sync_q, z_ack});
  end

  always_ff @(posedge ck or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (RESET_TOKEN && (i == 0)) ? RESET_VAL : '0;
      end
      wr_ptr_q <= AW'(RESET_TOKEN ? 1 : 0);
      rd_ptr_q <= '0;
      count_q  <= CW'(RESET_TOKEN ? 1 : 0);
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sync_q   <= '0;
      state_q  <= S_IDLE;
      hold_q   <= '0;
      z_d0_q   <= '0;
      z_d1_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      sync_q   <= sync_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      z_d0_q   <= z_d0_d;
      z_d1_q   <= z_d1_d;
    end
  end

  assign full = full_q;
  assign ovf  = ovf_q;
  assign z_d0 = z_d0_q;
  assign z_d1 = z_d1_q;

endmodule
`default_nettype wire

// File: tb/tb_sac_dualrail_fifo.sv
`default_nettype none
// ============================================================================
// tb_sac_dualrail_fifo : bench for the dual-rail sync-to-async FIFO channel
// Revision             : 1.0
// ============================================================================
module tb_sac_dualrail_fifo;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic         rst_b, en, z_ack, full, ovf;
  logic [W-1:0] a, z_d0, z_d1;
  logic         rst_b_t, en_t, z_ack_t, full_t, ovf_t;
  logic [W-1:0] a_t, z_d0_t, z_d1_t;
  logic         rst_b_i, en_i, z_ack_i, full_i, ovf_i;
  logic [W-1:0] a_i, z_d0_i, z_d1_i;

  int total = 0;
  int bad   = 0;

  sac_dualrail_fifo #(.W(W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .ck(ck), .rst_b(rst_b), .a(a), .en(en), .full(full), .ovf(ovf),
    .z_d0(z_d0), .z_d1(z_d1), .z_ack(z_ack));

  sac_dualrail_fifo #(.W(W), .DEPTH(DEPTH), .SYNC_STAGES(SS),
                      .RESET_TOKEN(1'b1), .RESET_VAL(8'h3C)) dut_tok (
    .ck(ck), .rst_b(rst_b_t), .a(a_t), .en(en_t), .full(full_t), .ovf(ovf_t),
    .z_d0(z_d0_t), .z_d1(z_d1_t), .z_ack(z_ack_t));

  sac_dualrail_fifo #(.W(W), .DEPTH(DEPTH), .SYNC_STAGES(SS),
                      .IGNORE_ACK(1'b1), .HOLD_CYC(3)) dut_ign (
    .ck(ck), .rst_b(rst_b_i), .a(a_i), .en(en_i), .full(full_i), .ovf(ovf_i),
    .z_d0(z_d0_i), .z_d1(z_d1_i), .z_ack(z_ack_i));

  task automatic apply_reset_main();
    rst_b = 1'b0; en = 1'b0; a = '0; z_ack = 1'b0;
    repeat (2) @(negedge ck);
    rst_b = 1'b1;
    @(negedge ck);
  endtask

  // Plays the receiver for one token on the main instance; no checking here.
  task automatic recv_main(output logic [W-1:0] val, output bit ok);
    int t;
    ok  = 1'b1;
    val = '0;
    t   = 0;
    while (t < 60 && !(&(z_d0 | z_d1))) begin @(negedge ck); t++; end
    if (t >= 60) begin ok = 1'b0; return; end
    val   = z_d1;
    z_ack = 1'b1;
    t     = 0;
    while (t < 60 && (z_d0 | z_d1) != '0) begin @(negedge ck); t++; end
    if (t >= 60) ok = 1'b0;
    z_ack = 1'b0;
    @(negedge ck);
  endtask

  task automatic test_reset();
    rst_b = 1'b0; en = 1'b0; a = '0; z_ack = 1'b0;
    @(negedge ck);
    total++;
    if (z_d0 !== '0 || z_d1 !== '0 || full !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: d0=%h d1=%h full=%b ovf=%b want 00 00 0 0", z_d0, z_d1, full, ovf);
    end
    rst_b = 1'b1;
    repeat (4) @(negedge ck);
    total++;
    if ((z_d0 | z_d1) !== '0 || full !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: d0=%h d1=%h full=%b want neutral, not full", z_d0, z_d1, full);
    end
  endtask

  task automatic test_single();
    int k;
    apply_reset_main();
    a = 8'hA5; en = 1'b1;
    @(negedge ck);
    en = 1'b0;
    total++;
    if (z_d0 !== '0 || z_d1 !== '0) begin
      bad++;
      $display("FAIL single_no_bypass: d1=%h d0=%h want 00 00", z_d1, z_d0);
    end
    @(negedge ck);
    total++;
    if (z_d1 !== 8'hA5 || z_d0 !== 8'h5A) begin
      bad++;
      $display("FAIL single_latency: d1=%h d0=%h want a5 5a", z_d1, z_d0);
    end
    repeat (3) @(negedge ck);
    total++;
    if (z_d1 !== 8'hA5 || z_d0 !== 8'h5A) begin
      bad++;
      $display("FAIL single_hold: d1=%h d0=%h want a5 5a", z_d1, z_d0);
    end
    z_ack = 1'b1;
    k = 0;
    while (k < 10 && (z_d0 | z_d1) != '0) begin @(negedge ck); k++; end
    total++;
    if (k < SS || k > SS + 1) begin
      bad++;
      $display("FAIL single_ack_to_rtz: edges=%0d want %0d..%0d", k, SS, SS + 1);
    end
    z_ack = 1'b0;
    repeat (5) @(negedge ck);
    total++;
    if ((z_d0 | z_d1) !== '0 || full !== 1'b0) begin
      bad++;
      $display("FAIL single_back_idle: d0=%h d1=%h full=%b want neutral, 0", z_d0, z_d1, full);
    end
  endtask

  task automatic test_burst();
    logic [W-1:0] v;
    bit           ok;
    int           errs;
    apply_reset_main();
    // First word pops one edge after its write, so five words fill the four slots.
    for (int i = 1; i <= 6; i++) begin
      a = W'(i); en = 1'b1;
      @(negedge ck);
      if (i == 4) begin
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL burst_full_early: full=%b want 0", full); end
      end
      if (i == 5) begin
        total++;
        if (full !== 1'b1 || ovf !== 1'b0) begin
          bad++; $display("FAIL burst_full: full=%b ovf=%b want 1 0", full, ovf);
        end
      end
    end
    en = 1'b0;
    total++;
    if (ovf !== 1'b1 || full !== 1'b1) begin
      bad++; $display("FAIL burst_ovf: ovf=%b full=%b want 1 1", ovf, full);
    end
    errs = 0;
    for (int i = 1; i <= 5; i++) begin
      recv_main(v, ok);
      if (!ok || v !== W'(i)) begin
        errs++;
        $display("FAIL burst_order: token %0d got %h ok=%0b want %h", i, v, ok, W'(i));
      end
    end
    total++;
    if (errs != 0) bad++;
    repeat (10) begin
      @(negedge ck);
      if ((z_d0 | z_d1) != '0) errs++;
    end
    total++;
    if (errs != 0 || ovf !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL burst_drop: extra=%0d ovf=%b full=%b want 0 1 0", errs, ovf, full);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w[3];
    logic [W-1:0] got[$];
    bit           pv, v, n, prev_v;
    int           gap, max_gap, bad_rail, cyc;
    apply_reset_main();
    for (int i = 0; i < 3; i++) w[i] = W'($urandom);
    for (int i = 0; i < 3; i++) begin a = w[i]; en = 1'b1; @(negedge ck); end
    en = 1'b0;
    pv = 1'b0; prev_v = 1'b0; gap = 0; max_gap = 0; bad_rail = 0; cyc = 0;
    while (cyc < 100 && !(got.size() == 3 && !z_ack && (z_d0 | z_d1) == '0)) begin
      v = &(z_d0 | z_d1);
      n = ((z_d0 | z_d1) == '0);
      if ((z_d0 & z_d1) != '0 || (!v && !n)) bad_rail++;
      if (v && !prev_v) begin
        if (got.size() > 0 && gap > max_gap) max_gap = gap;
        got.push_back(z_d1);
        gap = 0;
      end
      if (n) gap++;
      prev_v = v;
      z_ack  = pv;
      pv     = v;
      @(negedge ck);
      cyc++;
    end
    z_ack = 1'b0;
    total++;
    if (got.size() != 3) begin
      bad++; $display("FAIL b2b_count: tokens=%0d want 3", got.size());
    end else if (got[0] !== w[0] || got[1] !== w[1] || got[2] !== w[2]) begin
      bad++;
      $display("FAIL b2b_order: got %h %h %h want %h %h %h", got[0], got[1], got[2], w[0], w[1], w[2]);
    end
    total++;
    if (bad_rail != 0) begin bad++; $display("FAIL b2b_rails: bad samples=%0d want 0", bad_rail); end
    total++;
    if (max_gap > SS + 2) begin
      bad++; $display("FAIL b2b_no_idle: neutral gap=%0d want <=%0d", max_gap, SS + 2);
    end
  endtask

  task automatic test_reset_token();
    int t, extra;
    rst_b_t = 1'b0; en_t = 1'b0; a_t = '0; z_ack_t = 1'b0;
    repeat (2) @(negedge ck);
    total++;
    if ((z_d0_t | z_d1_t) !== '0) begin
      bad++; $display("FAIL tok_reset: d0=%h d1=%h want 00 00", z_d0_t, z_d1_t);
    end
    rst_b_t = 1'b1;
    t = 0;
    while (t < 10 && !(&(z_d0_t | z_d1_t))) begin @(negedge ck); t++; end
    total++;
    if (z_d1_t !== 8'h3C || z_d0_t !== 8'hC3) begin
      bad++; $display("FAIL tok_value: d1=%h d0=%h want 3c c3", z_d1_t, z_d0_t);
    end
    z_ack_t = 1'b1;
    t = 0;
    while (t < 20 && (z_d0_t | z_d1_t) != '0) begin @(negedge ck); t++; end
    z_ack_t = 1'b0;
    extra = (t >= 20) ? 1 : 0;
    repeat (12) begin
      @(negedge ck);
      if ((z_d0_t | z_d1_t) != '0) extra++;
    end
    total++;
    if (extra != 0 || full_t !== 1'b0) begin
      bad++; $display("FAIL tok_then_idle: busy samples=%0d full=%b want 0 0", extra, full_t);
    end
  endtask

  task automatic test_ignore_ack();
    logic [W-1:0] w1, w2;
    logic [W-1:0] sv[24];
    bit           sval[24], sneu[24];
    int           f, e1, e2, e3, e4;
    rst_b_i = 1'b0; en_i = 1'b0; a_i = '0; z_ack_i = 1'b0;
    repeat (2) @(negedge ck);
    rst_b_i = 1'b1;
    @(negedge ck);
    w1 = W'($urandom);
    w2 = w1 ^ 8'h81;
    a_i = w1; en_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge ck);
      if (i == 0) a_i = w2; else en_i = 1'b0;
      sv[i]   = z_d1_i;
      sval[i] = &(z_d0_i | z_d1_i) && ((z_d0_i & z_d1_i) == '0);
      sneu[i] = ((z_d0_i | z_d1_i) == '0);
    end
    f = -1;
    for (int i = 0; i < 24; i++) if (f < 0 && !sneu[i]) f = i;
    total++;
    if (f != 1) begin
      bad++; $display("FAIL ign_latency: first valid sample=%0d want 1", f);
    end else begin
      e1 = 0; e2 = 0; e3 = 0; e4 = 0;
      for (int i = 1; i <= 3; i++)  if (!sval[i] || sv[i] !== w1) e1++;
      for (int i = 4; i <= 6; i++)  if (!sneu[i]) e2++;
      for (int i = 7; i <= 9; i++)  if (!sval[i] || sv[i] !== w2) e3++;
      for (int i = 10; i < 24; i++) if (!sneu[i]) e4++;
      total++;
      if (e1 != 0) begin bad++; $display("FAIL ign_word1: bad samples=%0d want 0 (w=%h)", e1, w1); end
      total++;
      if (e2 != 0) begin bad++; $display("FAIL ign_neutral: bad samples=%0d want 0", e2); end
      total++;
      if (e3 != 0) begin bad++; $display("FAIL ign_word2: bad samples=%0d want 0 (w=%h)", e3, w2); end
      total++;
      if (e4 != 0) begin bad++; $display("FAIL ign_idle: busy samples=%0d want 0", e4); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] pend_val;
    bit           pend_wr, pend_ovf, model_ovf, prev_v, v, n;
    int           dly, cyc, errs, prob;
    apply_reset_main();
    pend_wr = 0; pend_ovf = 0; model_ovf = 0; prev_v = 0; dly = 0; cyc = 0; errs = 0;
    pend_val = '0;
    while (cyc < 700 && !(cyc >= 500 && q.size() == 0 && !pend_wr && !z_ack && (z_d0 | z_d1) == '0)) begin
      @(negedge ck);
      cyc++;
      v = &(z_d0 | z_d1);
      n = ((z_d0 | z_d1) == '0);
      if ((z_d0 & z_d1) != '0 || (!v && !n)) begin
        errs++; $display("FAIL rnd_rails: cyc=%0d d0=%h d1=%h", cyc, z_d0, z_d1);
      end
      if (v && !prev_v) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_token: cyc=%0d got %h want nothing queued", cyc, z_d1);
        end else if (z_d1 !== q[0] || z_d0 !== ~q[0]) begin
          bad++; $display("FAIL rnd_token: cyc=%0d got %h/%h want %h", cyc, z_d1, z_d0, q[0]);
          void'(q.pop_front());
        end else begin
          void'(q.pop_front());
        end
      end
      prev_v = v;
      if (pend_wr)  q.push_back(pend_val);
      if (pend_ovf) model_ovf = 1'b1;
      total++;
      if (full !== (q.size() == DEPTH) || ovf !== model_ovf) begin
        bad++;
        $display("FAIL rnd_flags: cyc=%0d full=%b ovf=%b want %b %b", cyc, full, ovf, q.size() == DEPTH, model_ovf);
      end
      if ((v && !z_ack) || (n && z_ack)) begin
        if (dly == 0) begin z_ack = ~z_ack; dly = $urandom_range(0, 3); end
        else dly--;
      end
      prob = (cyc < 250) ? 8 : 3;
      en       = (cyc < 500) && ($urandom_range(0, prob - 1) == 0);
      a        = W'($urandom);
      pend_val = a;
      pend_wr  = en && (q.size() < DEPTH);
      pend_ovf = en && (q.size() == DEPTH);
    end
    en = 1'b0;
    z_ack = 1'b0;
    total++;
    if (errs != 0 || q.size() != 0) begin
      bad++; $display("FAIL rnd_drain: rail errs=%0d left=%0d want 0 0", errs, q.size());
    end
  endtask

  task automatic test_midreset();
    int busy;
    apply_reset_main();
    for (int i = 0; i < 6; i++) begin a = W'($urandom); en = 1'b1; @(negedge ck); end
    en = 1'b0;
    total++;
    if (!(&(z_d0 | z_d1)) || full !== 1'b1 || ovf !== 1'b1) begin
      bad++; $display("FAIL midrst_setup: d1=%h full=%b ovf=%b want valid 1 1", z_d1, full, ovf);
    end
    @(posedge ck);
    #2 rst_b = 1'b0;
    #1;
    total++;
    if (z_d0 !== '0 || z_d1 !== '0 || full !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: d0=%h d1=%h full=%b ovf=%b want 00 00 0 0", z_d0, z_d1, full, ovf);
    end
    @(negedge ck);
    rst_b = 1'b1;
    busy = 0;
    repeat (8) begin
      @(negedge ck);
      if ((z_d0 | z_d1) != '0 || full !== 1'b0) busy++;
    end
    total++;
    if (busy != 0) begin bad++; $display("FAIL midrst_empty: busy samples=%0d want 0", busy); end
  endtask

  initial begin
    rst_b = 1'b0; en = 1'b0; a = '0; z_ack = 1'b0;
    rst_b_t = 1'b0; en_t = 1'b0; a_t = '0; z_ack_t = 1'b0;
    rst_b_i = 1'b0; en_i = 1'b0; a_i = '0; z_ack_i = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_reset_token();
    test_ignore_ack();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
